// File: rtl/io_stream_read_array_burst_pkg.sv
// -----------------------------------------------------------------------------
// io_stream_read_array_burst_pkg
// Shared primitives for the burst array reader: FSM state encoding and the
// default parameter values used by the top and its response buffer.
// -----------------------------------------------------------------------------
package io_stream_read_array_burst_pkg;

  localparam int unsigned DEF_INT_N  = 8;  // element data width
  localparam int unsigned DEF_ADDR_N = 8;  // array address width
  localparam int unsigned DEF_LEN_N  = 4;  // burst-length field width
  localparam int unsigned DEF_LAT    = 1;  // array read latency in cycles
  localparam int unsigned DEF_DEPTH  = 4;  // response buffer entries

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/io_stream_read_array_burst_fifo.sv
// -----------------------------------------------------------------------------
// io_stream_fifo
// Response buffer: power-of-two circular FIFO with a registered occupancy
// count. The head entry is shown combinationally from storage and forced to
// zero while the buffer is empty so no stale entry is visible.
//
// Ports
//   clk        in   rising-edge clock
//   nrst       in   asynchronous active-low reset
//   i_wr_en    in   push i_wr_data
//   i_wr_data  in   WIDTH bits
//   i_rd_en    in   pop head entry
//   o_rd_data  out  head entry (zero when empty)
//   o_count    out  current occupancy
//   o_empty    out  occupancy is zero
// -----------------------------------------------------------------------------
module io_stream_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  // Protective gating: a push into a full buffer or a pop from an empty one is ignored.
  assign w_wr = i_wr_en && (r_count != CW'(DEPTH));
  assign w_rd = i_rd_en && (r_count != {CW{1'b0}});

  assign o_count   = r_count;
  assign o_empty   = (r_count == {CW{1'b0}});
  assign o_rd_data = o_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1'b1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1'b1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1'b1);
        2'b01:   r_count <= r_count - CW'(1'b1);
        default: r_count <= r_count;  // idle, or push and pop together
      endcase
    end
  end

endmodule

// File: rtl/io_stream_read_array_burst.sv
// -----------------------------------------------------------------------------
// io_stream_read_array_burst
// Accepts (base address, length) commands and streams that many consecutive
// array elements out in order, with sOut_last marking the final beat. Array
// reads are issued only while the response buffer has room for everything
// already requested, so the fixed-latency array never has to be stalled.
//
// Ports
//   clk, nrst                   clock, asynchronous active-low reset
//   sIn, sIn_len                command base address / burst length
//   sIn_valid, sIn_ready        command handshake
//   sOut, sOut_last             read data / final beat of burst
//   sOut_valid, sOut_ready      output handshake
//   arr_addr, arr_valid         array read request
//   arr_ready                   array accepts request
//   arr_data                    array data, valid LAT cycles after accept
// -----------------------------------------------------------------------------
module io_stream_read_array_burst
  import io_stream_read_array_burst_pkg::*;
#(
  parameter int unsigned intN  = DEF_INT_N,
  parameter int unsigned addrN = DEF_ADDR_N,
  parameter int unsigned LENN  = DEF_LEN_N,
  parameter int unsigned LAT   = DEF_LAT,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [addrN-1:0] sIn,
  input  logic [LENN-1:0]  sIn_len,
  input  logic             sIn_valid,
  output logic             sIn_ready,
  output logic [intN-1:0]  sOut,
  output logic             sOut_last,
  output logic             sOut_valid,
  input  logic             sOut_ready,
  output logic [addrN-1:0] arr_addr,
  output logic             arr_valid,
  input  logic             arr_ready,
  input  logic [intN-1:0]  arr_data
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [addrN-1:0] r_addr;
  logic [addrN-1:0] w_addr_nxt;
  logic [LENN-1:0]  r_remaining;
  logic [LENN-1:0]  w_remaining_nxt;
  logic             r_sin_ready;
  logic [LAT-1:0]   r_pipe_valid;
  logic [LAT-1:0]   r_pipe_last;
  logic             w_cmd_acc;
  logic             w_arr_acc;
  logic             w_out_acc;
  logic             w_arr_last;
  logic             w_credit_ok;
  logic [15:0]      w_inflight;
  logic [15:0]      w_used;
  logic [CW-1:0]    w_count;
  logic             w_empty;
  logic [intN:0]    w_head;

  assign sIn_ready  = r_sin_ready;
  assign w_cmd_acc  = sIn_valid && r_sin_ready;
  assign arr_addr   = r_addr;
  assign arr_valid  = (r_state == ST_ISSUE) && w_credit_ok;
  assign w_arr_acc  = arr_valid && arr_ready;
  assign w_arr_last = (r_remaining == LENN'(1'b1));
  assign sOut_valid = !w_empty;
  assign w_out_acc  = sOut_valid && sOut_ready;
  assign sOut       = w_head[intN-1:0];
  assign sOut_last  = w_head[intN];

  // Credit check: reads in the pipe plus buffered beats must fit in the
  // buffer. A pop this cycle frees a slot now, which keeps 1 beat/cycle
  // possible even when DEPTH is only LAT+1.
  always_comb begin
    w_inflight = 16'd0;
    for (int i = 0; i < int'(LAT); i++) begin
      w_inflight = w_inflight + 16'(r_pipe_valid[i]);
    end
    w_used      = w_inflight + 16'(w_count);
    w_credit_ok = (w_used < (16'(DEPTH) + 16'(w_out_acc)));
  end

  // Command FSM next-state: latch a burst in IDLE, step address/count in ISSUE.
  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_remaining_nxt = r_remaining;
    case (r_state)
      ST_IDLE: begin
        // Zero-length commands are accepted and dropped without leaving IDLE.
        if (w_cmd_acc && (sIn_len != {LENN{1'b0}})) begin
          w_addr_nxt      = sIn;
          w_remaining_nxt = sIn_len;
          w_state_nxt     = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (w_arr_acc) begin
          w_addr_nxt      = r_addr + addrN'(1'b1);
          w_remaining_nxt = r_remaining - LENN'(1'b1);
          w_state_nxt     = w_arr_last ? ST_IDLE : ST_ISSUE;
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state and burst registers; command ready follows the next state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= ST_IDLE;
      r_addr      <= {addrN{1'b0}};
      r_remaining <= {LENN{1'b0}};
      r_sin_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_remaining <= w_remaining_nxt;
      r_sin_ready <= (w_state_nxt == ST_IDLE);
    end
  end

  // Read-latency pipe: the tail stage marks the edge at which arr_data holds
  // the element for an accept made LAT cycles earlier.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pipe_valid <= {LAT{1'b0}};
      r_pipe_last  <= {LAT{1'b0}};
    end else begin
      r_pipe_valid[0] <= w_arr_acc;
      r_pipe_last[0]  <= w_arr_acc && w_arr_last;
      for (int i = 1; i < int'(LAT); i++) begin
        r_pipe_valid[i] <= r_pipe_valid[i-1];
        r_pipe_last[i]  <= r_pipe_last[i-1];
      end
    end
  end

  io_stream_fifo #(
    .WIDTH (intN + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .i_wr_en   (r_pipe_valid[LAT-1]),
    .i_wr_data ({r_pipe_last[LAT-1], arr_data}),
    .i_rd_en   (w_out_acc),
    .o_rd_data (w_head),
    .o_count   (w_count),
    .o_empty   (w_empty)
  );

endmodule

// File: tb/tb_io_stream_read_array_burst.sv
module tb_io_stream_read_array_burst;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  // DUT with LAT=1
  logic [7:0] s1_in = 8'd0;
  logic [3:0] s1_len = 4'd0;
  logic       s1_in_valid = 1'b0, s1_in_ready;
  logic [7:0] s1_out;
  logic       s1_last, s1_out_valid, s1_out_ready = 1'b1;
  logic [7:0] a1_addr, a1_data, a1_d;
  logic       a1_valid, a1_ready = 1'b1;

  // DUT with LAT=3
  logic [7:0] s3_in = 8'd0;
  logic [3:0] s3_len = 4'd0;
  logic       s3_in_valid = 1'b0, s3_in_ready;
  logic [7:0] s3_out;
  logic       s3_last, s3_out_valid, s3_out_ready = 1'b1;
  logic [7:0] a3_addr, a3_data, a3_d0, a3_d1, a3_d2;
  logic       a3_valid, a3_ready = 1'b1;

  io_stream_read_array_burst #(.intN(8), .addrN(8), .LENN(4), .LAT(1), .DEPTH(4)) u_dut1 (
    .clk(clk), .nrst(nrst), .sIn(s1_in), .sIn_len(s1_len), .sIn_valid(s1_in_valid),
    .sIn_ready(s1_in_ready), .sOut(s1_out), .sOut_last(s1_last), .sOut_valid(s1_out_valid),
    .sOut_ready(s1_out_ready), .arr_addr(a1_addr), .arr_valid(a1_valid),
    .arr_ready(a1_ready), .arr_data(a1_data)
  );

  io_stream_read_array_burst #(.intN(8), .addrN(8), .LENN(4), .LAT(3), .DEPTH(4)) u_dut3 (
    .clk(clk), .nrst(nrst), .sIn(s3_in), .sIn_len(s3_len), .sIn_valid(s3_in_valid),
    .sIn_ready(s3_in_ready), .sOut(s3_out), .sOut_last(s3_last), .sOut_valid(s3_out_valid),
    .sOut_ready(s3_out_ready), .arr_addr(a3_addr), .arr_valid(a3_valid),
    .arr_ready(a3_ready), .arr_data(a3_data)
  );

  // Array models with array[i] = i and fixed read latency of 1 and 3 cycles.
  always @(posedge clk) begin
    a1_d  <= a1_addr;
    a3_d0 <= a3_addr;
    a3_d1 <= a3_d0;
    a3_d2 <= a3_d1;
  end
  assign a1_data = a1_d;
  assign a3_data = a3_d2;

  // Observed beats and issued array addresses.
  logic [7:0] q1_data[$];
  logic       q1_last[$];
  int         q1_cyc[$];
  logic [7:0] qa1[$];
  logic [7:0] q3_data[$];
  logic       q3_last[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (nrst) begin
      if (s1_out_valid && s1_out_ready) begin
        q1_data.push_back(s1_out);
        q1_last.push_back(s1_last);
        q1_cyc.push_back(cyc);
      end
      if (a1_valid && a1_ready) qa1.push_back(a1_addr);
      if (s3_out_valid && s3_out_ready) begin
        q3_data.push_back(s3_out);
        q3_last.push_back(s3_last);
      end
    end
  end

  task automatic clear1();
    q1_data.delete(); q1_last.delete(); q1_cyc.delete(); qa1.delete();
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send1(input logic [7:0] base, input logic [3:0] len);
    int n = 0;
    s1_in = base; s1_len = len; s1_in_valid = 1'b1;
    while (!s1_in_ready && n < 50) begin
      @(negedge clk); n++;
    end
    checks++;
    if (s1_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept base=%0d: ready=%0b required=1", base, s1_in_ready);
    end
    @(negedge clk);
    s1_in_valid = 1'b0;
  endtask

  task automatic wait_beats1(input int n, input int budget);
    int k = 0;
    while (q1_data.size() < n && k < budget) begin
      @(negedge clk); k++;
    end
    checks++;
    if (q1_data.size() < n) begin
      errors++;
      $display("FAIL beat_timeout: got %0d beats required %0d", q1_data.size(), n);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({s1_in_ready, a1_valid, a1_addr, s1_out_valid, s1_out, s1_last} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%0b av=%0b aa=%0d ov=%0b o=%0d l=%0b required all 0",
               s1_in_ready, a1_valid, a1_addr, s1_out_valid, s1_out, s1_last);
    end
    checks++;
    if ({s3_in_ready, a3_valid, s3_out_valid} !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs_lat3: rdy=%0b av=%0b ov=%0b required 0", s3_in_ready, a3_valid, s3_out_valid);
    end
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    checks++;
    if (s1_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %0b required 1", s1_in_ready);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_d[4] = '{8'd3, 8'd4, 8'd5, 8'd6};
    clear1();
    s1_out_ready = 1'b1; a1_ready = 1'b1;
    send1(8'd3, 4'd4);
    wait_beats1(4, 40);
    repeat (4) @(negedge clk);
    checks++;
    if (q1_data.size() != 4) begin
      errors++;
      $display("FAIL basic_count: got %0d required 4", q1_data.size());
    end
    for (int i = 0; i < 4 && i < q1_data.size(); i++) begin
      checks++;
      if (q1_data[i] !== exp_d[i] || q1_last[i] !== (i == 3)) begin
        errors++;
        $display("FAIL basic_beat%0d: data=%0d last=%0b required data=%0d last=%0b",
                 i, q1_data[i], q1_last[i], exp_d[i], (i == 3));
      end
    end
    for (int i = 1; i < 4 && i < q1_cyc.size(); i++) begin
      checks++;
      if (q1_cyc[i] !== q1_cyc[0] + i) begin
        errors++;
        $display("FAIL basic_throughput%0d: cycle=%0d required %0d", i, q1_cyc[i], q1_cyc[0] + i);
      end
    end
    checks++;
    if (s1_in_ready !== 1'b1 || s1_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: ready=%0b out_valid=%0b required 1/0", s1_in_ready, s1_out_valid);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_d[6] = '{8'd252, 8'd253, 8'd254, 8'd255, 8'd0, 8'd1};
    clear1();
    send1(8'd252, 4'd6);
    wait_beats1(6, 40);
    repeat (3) @(negedge clk);
    checks++;
    if (q1_data.size() != 6 || qa1.size() != 6) begin
      errors++;
      $display("FAIL wrap_count: beats=%0d reads=%0d required 6/6", q1_data.size(), qa1.size());
    end
    for (int i = 0; i < 6 && i < q1_data.size() && i < qa1.size(); i++) begin
      checks++;
      if (q1_data[i] !== exp_d[i] || qa1[i] !== exp_d[i] || q1_last[i] !== (i == 5)) begin
        errors++;
        $display("FAIL wrap_beat%0d: data=%0d addr=%0d last=%0b required %0d/%0d/%0b",
                 i, q1_data[i], qa1[i], q1_last[i], exp_d[i], exp_d[i], (i == 5));
      end
    end
  endtask

  task automatic test_backpressure();
    clear1();
    s1_out_ready = 1'b0;
    send1(8'd0, 4'd15);
    repeat (10) @(negedge clk);
    checks++;
    if (qa1.size() != 4 || q1_data.size() != 0) begin
      errors++;
      $display("FAIL bp_credit: reads=%0d beats=%0d required 4/0", qa1.size(), q1_data.size());
    end
    checks++;
    if (s1_out_valid !== 1'b1 || s1_out !== 8'd0 || s1_last !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: valid=%0b data=%0d last=%0b required 1/0/0", s1_out_valid, s1_out, s1_last);
    end
    s1_out_ready = 1'b1;
    wait_beats1(15, 80);
    repeat (3) @(negedge clk);
    checks++;
    if (q1_data.size() != 15) begin
      errors++;
      $display("FAIL bp_count: got %0d required 15", q1_data.size());
    end
    for (int i = 0; i < 15 && i < q1_data.size(); i++) begin
      checks++;
      if (q1_data[i] !== 8'(i) || q1_last[i] !== (i == 14)) begin
        errors++;
        $display("FAIL bp_beat%0d: data=%0d last=%0b required %0d/%0b", i, q1_data[i], q1_last[i], i, (i == 14));
      end
    end
  endtask

  task automatic test_back_to_back();
    clear1();
    s1_in = 8'd100; s1_len = 4'd0; s1_in_valid = 1'b1;
    checks++;
    if (s1_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_ready: got %0b required 1", s1_in_ready);
    end
    @(negedge clk);
    s1_in = 8'd8; s1_len = 4'd2;
    checks++;
    if (s1_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_ready: got %0b required 1", s1_in_ready);
    end
    @(negedge clk);
    s1_in_valid = 1'b0;
    wait_beats1(2, 30);
    repeat (5) @(negedge clk);
    checks++;
    if (q1_data.size() != 2 || qa1.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: beats=%0d reads=%0d required 2/2", q1_data.size(), qa1.size());
    end
    for (int i = 0; i < 2 && i < q1_data.size(); i++) begin
      checks++;
      if (q1_data[i] !== 8'(8 + i) || q1_last[i] !== (i == 1)) begin
        errors++;
        $display("FAIL b2b_beat%0d: data=%0d last=%0b required %0d/%0b", i, q1_data[i], q1_last[i], 8 + i, (i == 1));
      end
    end
  endtask

  task automatic test_lat3_toggle();
    int n = 0;
    q3_data.delete(); q3_last.delete();
    s3_out_ready = 1'b1; a3_ready = 1'b0;
    @(negedge clk);
    s3_in = 8'd0; s3_len = 4'd15; s3_in_valid = 1'b1;
    while (!s3_in_ready && n < 50) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    s3_in_valid = 1'b0;
    n = 0;
    while (q3_data.size() < 15 && n < 300) begin
      a3_ready = ~a3_ready;
      @(negedge clk); n++;
    end
    a3_ready = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (q3_data.size() != 15) begin
      errors++;
      $display("FAIL lat3_count: got %0d required 15", q3_data.size());
    end
    for (int i = 0; i < 15 && i < q3_data.size(); i++) begin
      checks++;
      if (q3_data[i] !== 8'(i) || q3_last[i] !== (i == 14)) begin
        errors++;
        $display("FAIL lat3_beat%0d: data=%0d last=%0b required %0d/%0b", i, q3_data[i], q3_last[i], i, (i == 14));
      end
    end
  endtask

  task automatic test_reset_mid();
    clear1();
    s1_out_ready = 1'b1; a1_ready = 1'b1;
    send1(8'd0, 4'd15);
    repeat (3) @(negedge clk);
    #1 nrst = 1'b0;
    #1;
    checks++;
    if ({s1_in_ready, a1_valid, a1_addr, s1_out_valid, s1_out, s1_last} !== 19'd0) begin
      errors++;
      $display("FAIL midreset_outputs: rdy=%0b av=%0b aa=%0d ov=%0b o=%0d l=%0b required all 0",
               s1_in_ready, a1_valid, a1_addr, s1_out_valid, s1_out, s1_last);
    end
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    clear1();
    send1(8'd5, 4'd1);
    wait_beats1(1, 30);
    repeat (6) @(negedge clk);
    checks++;
    if (q1_data.size() != 1 || qa1.size() != 1) begin
      errors++;
      $display("FAIL midreset_count: beats=%0d reads=%0d required 1/1", q1_data.size(), qa1.size());
    end
    if (q1_data.size() > 0) begin
      checks++;
      if (q1_data[0] !== 8'd5 || q1_last[0] !== 1'b1) begin
        errors++;
        $display("FAIL midreset_beat: data=%0d last=%0b required 5/1", q1_data[0], q1_last[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_lat3_toggle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
